msrv32_load_unit_seq: RTL and testbench
=======================================

// Module: msrv32_load_unit_seq
// PURPOSE
//  Sequential, parametrised load unit sitting between the MEM/WB stage and the data-memory port.
//  Accepts a load request, issues one or two XLEN-aligned memory beats, and waits on ahb_resp_in per beat.
//  Extracts, aligns and sign/zero-extends the requested byte/half/word/dword, then returns it with a 1-cycle valid pulse.
//  Generalises the combinational load unit: variable XLEN, handshake, wait states, misaligned split.
// PARAMETERS
//  XLEN    32  datapath width; 32 or 64 only
//  ADDR_W  32  byte-address width
// PORTS
//  ms_riscv32_mp_clk_in     in   1       clock, all state on rising edge
//  ms_riscv32_mp_rst_in     in   1       synchronous, active-high reset
//  load_req_in              in   1       load request; accepted only when load_ready_out=1
//  load_addr_in             in   ADDR_W  byte address of load
//  load_size_in             in   2       00 byte, 01 half, 10 word, 11 dword (XLEN=64; word when XLEN=32)
//  load_unsigned_in         in   1       1 = zero-extend, 0 = sign-extend
//  load_ready_out           out  1       unit idle, can accept a request
//  dm_req_out               out  1       memory beat request, held until ahb_resp_in
//  dm_addr_out              out  ADDR_W  XLEN-aligned beat address (low log2(XLEN/8) bits 0)
//  ahb_resp_in              in   1       beat data valid; sampled only while dm_req_out=1
//  ms_riscv32_mp_dmdata_in  in   XLEN    beat read data, little-endian
//  lu_output_out            out  XLEN    extended load result, valid with lu_valid_out
//  lu_valid_out             out  1       one-cycle result pulse
//  lu_misaligned_out        out  1       misaligned-fault flag, valid with lu_valid_out
// BEHAVIOUR
//  - Reset: state IDLE; load_ready_out=1; dm_req_out, dm_addr_out, lu_output_out, lu_valid_out, lu_misaligned_out = 0.
//  - Reset mid-operation: transaction dropped; no lu_valid_out; dm_req_out=0 the cycle after reset is sampled.
//  - States: IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE.
//  - IDLE: load_ready_out=1; on load_req_in, latch addr/size/unsigned and go BEAT0; dm_req_out=1 next cycle.
//  - BEAT0/BEAT1: dm_req_out=1; dm_addr_out=aligned addr (BEAT1: +XLEN/8, wraps mod 2^ADDR_W).
//    ahb_resp_in=1 captures dmdata. Wait states hold the state and dm_req_out indefinitely.
//  - BEAT0 -> BEAT1 if crossing, else RESP. BEAT1 -> RESP. RESP: lu_valid_out=1 one cycle, then IDLE.
//  - load_req_in outside IDLE is ignored (not queued). ahb_resp_in with dm_req_out=0 is ignored.
//  - Latency: accept at cycle N, dm_req_out at N+1; zero wait states -> lu_valid_out at N+2 (N+3 when split).
//  - Arithmetic: off = addr[log2(XLEN/8)-1:0]; nbytes = 1<<size (size 11 -> 4 when XLEN=32).
//    Crossing iff off+nbytes > XLEN/8.
//  - Result: take {beat1,beat0} >> (8*off), keep nbytes low bytes, extend per load_unsigned_in.
//    Full-XLEN load ignores unsigned.
//  - lu_output_out/lu_misaligned_out hold their value after the pulse until the next RESP.
//  - Intra-beat misalignment (e.g. half at off=1) is always legal, single beat.
// CONFIGURATION
//  MISALIGN_SPLIT_EN defined: crossing loads split into two beats as above; lu_misaligned_out is always 0.
//  MISALIGN_SPLIT_EN undefined: crossing load skips the memory access (IDLE -> RESP directly).
//    The next cycle gives lu_valid_out=1, lu_misaligned_out=1, lu_output_out=0.
// TESTING (XLEN=32 unless noted)
//  1 LB addr 0x101, signed, resp same cycle, data 0xA5A5A5A5 -> dm_addr_out 0x100, lu_output_out 0xFFFFFFA5, valid 2 cycles after accept.
//  2 LBU addr 0x102, data 0x34567A43 -> 0x00000056; LHU addr 0x102 -> 0x00003456.
//  3 LW addr 0x200, ahb_resp_in delayed 3 cycles, data 0x0234567A -> dm_req_out high 4 cycles, result 0x0234567A, one valid pulse.
//  4 LH signed addr 0x103, split on: beat0 @0x100 0x11223344, beat1 @0x104 0x556677A8 -> 0xFFFFA811, misaligned 0.
//    Split off: no dm_req_out, misaligned 1, output 0.
//  5 Reset asserted during BEAT0 wait -> no lu_valid_out, load_ready_out=1 and dm_req_out=0 the cycle after; load_req_in while busy -> ignored, single result.
//  6 XLEN=64 LD addr 0x8, data 0x8000000012345678 -> 0x8000000012345678; LW signed addr 0xC same data -> 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/msrv32_load_unit_seq.sv
// msrv32_load_unit_seq: sequential load unit with wait states and sign/zero extension.
// Define MISALIGN_SPLIT_EN to split beat-crossing loads into two beats instead of faulting.
module msrv32_load_unit_seq #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic              load_req_in,
    input  logic [ADDR_W-1:0] load_addr_in,
    input  logic [1:0]        load_size_in,
    input  logic              load_unsigned_in,
    output logic              load_ready_out,
    output logic              dm_req_out,
    output logic [ADDR_W-1:0] dm_addr_out,
    input  logic              ahb_resp_in,
    input  logic [XLEN-1:0]   ms_riscv32_mp_dmdata_in,
    output logic [XLEN-1:0]   lu_output_out,
    output logic              lu_valid_out,
    output logic              lu_misaligned_out
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state;
    logic [OB-1:0] off_q;
    logic [1:0] size_q;
    logic uns_q;
    logic [XLEN-1:0] beat0_q, sh, mask, sgn_fill, ext;
    logic [2*XLEN-1:0] cat;
    logic split, done;

    function automatic logic [3:0] nbytes(input logic [1:0] s);
        return (XLEN == 32 && s == 2'd3) ? 4'd4 : 4'd1 << s;
    endfunction

    function automatic logic crosses(input logic [OB-1:0] off, input logic [1:0] s);
        return 5'(off) + 5'(nbytes(s)) > 5'(NB);
    endfunction

    // Sign bit is the top bit still inside the byte mask, so no variable bit-select is needed
    always_comb begin
        cat = state == BEAT1 ? {ms_riscv32_mp_dmdata_in, beat0_q} : {{XLEN{1'b0}}, ms_riscv32_mp_dmdata_in};
        sh = XLEN'(cat >> {off_q, 3'b000});
        mask = ~({XLEN{1'b1}} << {nbytes(size_q), 3'b000});
        sgn_fill = (!uns_q && |(sh & mask & ~(mask >> 1))) ? ~mask : '0;
        ext = (sh & mask) | sgn_fill;
`ifdef MISALIGN_SPLIT_EN
        split = state == BEAT0 && crosses(off_q, size_q);
`else
        split = 1'b0;
`endif
        done = ahb_resp_in && (state == BEAT1 || (state == BEAT0 && !split));
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state <= IDLE;
            load_ready_out <= 1'b1;
            dm_req_out <= 1'b0;
            dm_addr_out <= '0;
            lu_output_out <= '0;
            lu_valid_out <= 1'b0;
            lu_misaligned_out <= 1'b0;
            off_q <= '0;
            size_q <= '0;
            uns_q <= 1'b0;
            beat0_q <= '0;
        end else begin
            lu_valid_out <= 1'b0;
            case (state)
                IDLE: if (load_req_in) begin
                    off_q <= load_addr_in[OB-1:0];
                    size_q <= load_size_in;
                    uns_q <= load_unsigned_in;
                    load_ready_out <= 1'b0;
                    dm_addr_out <= {load_addr_in[ADDR_W-1:OB], OB'(0)};
`ifndef MISALIGN_SPLIT_EN
                    if (crosses(load_addr_in[OB-1:0], load_size_in)) begin
                        state <= RESP;
                        lu_valid_out <= 1'b1;
                        lu_output_out <= '0;
                        lu_misaligned_out <= 1'b1;
                    end else
`endif
                    begin
                        state <= BEAT0;
                        dm_req_out <= 1'b1;
                    end
                end
                BEAT0, BEAT1: begin
                    if (ahb_resp_in) beat0_q <= ms_riscv32_mp_dmdata_in;
                    if (split && ahb_resp_in) begin
                        state <= BEAT1;
                        dm_addr_out <= dm_addr_out + ADDR_W'(NB);
                    end
                    if (done) begin
                        state <= RESP;
                        dm_req_out <= 1'b0;
                        lu_valid_out <= 1'b1;
                        lu_output_out <= ext;
                        lu_misaligned_out <= 1'b0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    load_ready_out <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msrv32_load_unit_seq.sv
// tb_msrv32_load_unit_seq: directed bench for 32- and 64-bit load units against a byte-level model.
module tb_msrv32_load_unit_seq;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic req32 = 1'b0, req64 = 1'b0, resp32 = 1'b0, resp64 = 1'b0, uns = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0] size = '0;
    logic [63:0] data = '0;
    logic ready32, dmreq32, v32, mis32, ready64, dmreq64, v64, mis64;
    logic [31:0] dmaddr32, dmaddr64, out32;
    logic [63:0] out64;
    logic [64:0] q32[$], q64[$];
    logic [64:0] x32, x64;
    int checks = 0, errors = 0, pulses32 = 0, pulses64 = 0, p;

    always #5 clk = ~clk;

    msrv32_load_unit_seq #(.XLEN(32), .ADDR_W(32)) u32 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .load_req_in(req32),
        .load_addr_in(addr), .load_size_in(size), .load_unsigned_in(uns), .load_ready_out(ready32),
        .dm_req_out(dmreq32), .dm_addr_out(dmaddr32), .ahb_resp_in(resp32),
        .ms_riscv32_mp_dmdata_in(data[31:0]), .lu_output_out(out32), .lu_valid_out(v32),
        .lu_misaligned_out(mis32));

    msrv32_load_unit_seq #(.XLEN(64), .ADDR_W(32)) u64 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .load_req_in(req64),
        .load_addr_in(addr), .load_size_in(size), .load_unsigned_in(uns), .load_ready_out(ready64),
        .dm_req_out(dmreq64), .dm_addr_out(dmaddr64), .ahb_resp_in(resp64),
        .ms_riscv32_mp_dmdata_in(data), .lu_output_out(out64), .lu_valid_out(v64),
        .lu_misaligned_out(mis64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Byte-array view of the two beats: pick nbytes from off, then extend to xl bits
    function automatic logic [63:0] model(input logic [31:0] a, input logic [1:0] sz, input logic u,
                                          input logic [63:0] b0, input logic [63:0] b1, input int xl,
                                          output logic mis);
        int nbw, off, n;
        logic [7:0] by[16];
        logic [63:0] v;
        nbw = xl / 8;
        off = int'(a % nbw);
        n = (sz == 2'd3 && xl == 32) ? 4 : (1 << sz);
        v = '0;
        mis = 1'b0;
        for (int i = 0; i < 16; i++) by[i] = 8'h00;
        for (int i = 0; i < nbw; i++) begin
            by[i] = b0[8*i +: 8];
            by[nbw+i] = b1[8*i +: 8];
        end
        if (off + n > nbw && !SPLIT) begin
            mis = 1'b1;
            return '0;
        end
        for (int i = 0; i < n; i++) v[8*i +: 8] = by[off+i];
        if (!u && n * 8 < xl && v[8*n-1]) for (int i = n * 8; i < xl; i++) v[i] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) if (!rst) begin
        if (v32) begin
            pulses32++;
            if (q32.size() == 0) chk("unexpected_valid32", 64'(v32), 64'd0);
            else begin
                x32 = q32.pop_front();
                chk("lu_output32", 64'(out32), x32[63:0]);
                chk("lu_mis32", 64'(mis32), 64'(x32[64]));
            end
        end
        if (v64) begin
            pulses64++;
            if (q64.size() == 0) chk("unexpected_valid64", 64'(v64), 64'd0);
            else begin
                x64 = q64.pop_front();
                chk("lu_output64", out64, x64[63:0]);
                chk("lu_mis64", 64'(mis64), 64'(x64[64]));
            end
        end
    end

    task automatic do_load(input bit w64, input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input logic [63:0] d0, input logic [63:0] d1, input int w0, input int w1,
                           input bit hold, input logic [63:0] lit, input logic lit_mis);
        logic [63:0] e;
        logic m;
        int nbw, off, n, nbeats, wt;
        logic [31:0] ba;
        e = model(a, sz, u, d0, d1, w64 ? 64 : 32, m);
        chk("model_value", e, lit);
        chk("model_mis", 64'(m), 64'(lit_mis));
        nbw = w64 ? 8 : 4;
        off = int'(a % nbw);
        n = (sz == 2'd3 && !w64) ? 4 : (1 << sz);
        nbeats = (off + n > nbw) ? (SPLIT ? 2 : 0) : 1;
        ba = a & ~32'(nbw - 1);
        @(negedge clk);
        chk("ready_idle", 64'(w64 ? ready64 : ready32), 64'd1);
        if (w64) begin q64.push_back({m, e}); req64 = 1'b1; end
        else begin q32.push_back({m, e}); req32 = 1'b1; end
        addr = a; size = sz; uns = u;
        @(negedge clk);
        if (!hold) begin req32 = 1'b0; req64 = 1'b0; end
        chk("ready_busy", 64'(w64 ? ready64 : ready32), 64'd0);
        for (int b = 0; b < nbeats; b++) begin
            wt = b ? w1 : w0;
            for (int w = 0; w <= wt; w++) begin
                chk("dm_req", 64'(w64 ? dmreq64 : dmreq32), 64'd1);
                chk("dm_addr", 64'(w64 ? dmaddr64 : dmaddr32), 64'(ba + 32'(b * nbw)));
                data = (w == wt) ? (b ? d1 : d0) : 64'hDEADBEEF_DEADBEEF;
                resp32 = !w64 && w == wt;
                resp64 = w64 && w == wt;
                @(negedge clk);
            end
        end
        resp32 = 1'b0; resp64 = 1'b0; req32 = 1'b0; req64 = 1'b0;
        chk("dm_req_done", 64'(w64 ? dmreq64 : dmreq32), 64'd0);
        chk("valid_latency", 64'(w64 ? v64 : v32), 64'd1);
        @(negedge clk);
        chk("valid_one_cycle", 64'(w64 ? v64 : v32), 64'd0);
        chk("ready_after", 64'(w64 ? ready64 : ready32), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready32", 64'(ready32), 64'd1);
        chk("rst_dmreq32", 64'(dmreq32), 64'd0);
        chk("rst_dmaddr32", 64'(dmaddr32), 64'd0);
        chk("rst_out32", 64'(out32), 64'd0);
        chk("rst_valid32", 64'(v32), 64'd0);
        chk("rst_mis32", 64'(mis32), 64'd0);
        chk("rst_ready64", 64'(ready64), 64'd1);
        chk("rst_dmreq64", 64'(dmreq64), 64'd0);
        chk("rst_out64", out64, 64'd0);
        chk("rst_valid64", 64'(v64), 64'd0);
        rst = 1'b0;
        do_load(0, 32'h101, 2'd0, 1'b0, 64'hA5A5A5A5, 64'h0, 0, 0, 0, 64'hFFFFFFA5, 1'b0);
        do_load(0, 32'h102, 2'd0, 1'b1, 64'h34567A43, 64'h0, 0, 0, 0, 64'h56, 1'b0);
        do_load(0, 32'h102, 2'd1, 1'b1, 64'h34567A43, 64'h0, 1, 0, 0, 64'h3456, 1'b0);
        do_load(0, 32'h200, 2'd2, 1'b0, 64'h0234567A, 64'h0, 3, 0, 0, 64'h0234567A, 1'b0);
        do_load(0, 32'h101, 2'd1, 1'b0, 64'h1280FF00, 64'h0, 0, 0, 0, 64'hFFFF80FF, 1'b0);
        do_load(0, 32'h300, 2'd3, 1'b1, 64'h80000001, 64'h0, 0, 0, 0, 64'h80000001, 1'b0);
        do_load(0, 32'h103, 2'd1, 1'b0, 64'h11223344, 64'h556677A8, 0, 0, 0,
                SPLIT ? 64'hFFFFA811 : 64'h0, !SPLIT);
        do_load(0, 32'hFFFFFFFE, 2'd2, 1'b0, 64'hAABBCCDD, 64'h11223344, 1, 2, 0,
                SPLIT ? 64'h3344AABB : 64'h0, !SPLIT);
        p = pulses32;
        do_load(0, 32'h100, 2'd0, 1'b0, 64'h0000007F, 64'h0, 2, 0, 1, 64'h7F, 1'b0);
        @(negedge clk);
        chk("busy_req_single_pulse", 64'(pulses32 - p), 64'd1);
        @(negedge clk);
        req32 = 1'b1; addr = 32'h400; size = 2'd2; uns = 1'b0;
        @(negedge clk);
        req32 = 1'b0;
        chk("rst_mid_dmreq_busy", 64'(dmreq32), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 64'(ready32), 64'd1);
        chk("rst_mid_dmreq", 64'(dmreq32), 64'd0);
        chk("rst_mid_valid", 64'(v32), 64'd0);
        rst = 1'b0;
        p = pulses32;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_pulse", 64'(pulses32 - p), 64'd0);
        do_load(1, 32'h8, 2'd3, 1'b0, 64'h8000000012345678, 64'h0, 0, 0, 0, 64'h8000000012345678, 1'b0);
        do_load(1, 32'hC, 2'd2, 1'b0, 64'h8000000012345678, 64'h0, 1, 0, 0, 64'hFFFFFFFF80000000, 1'b0);
        do_load(1, 32'hF, 2'd0, 1'b0, 64'h8000000012345678, 64'h0, 0, 0, 0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        do_load(1, 32'h6, 2'd2, 1'b1, 64'h0102030405060708, 64'h1112131415161718, 0, 1, 0,
                SPLIT ? 64'h17180102 : 64'h0, !SPLIT);
        repeat (2) @(negedge clk);
        chk("queue32_drained", 64'(q32.size()), 64'd0);
        chk("queue64_drained", 64'(q64.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
